// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: default widths, state type and NOP control word.
// The skid buffer is selected by the PIPE_STAGE_SKID_EN macro in pipe_stage_elastic.
package pipe_pkg;

   localparam int PIPE_CTRL_W = 16;
   localparam int PIPE_DATA_W = 96;
   localparam int PIPE_CNT_W  = 16;

   // All enables deasserted: the decoder and hazard unit emit this to squash a slot.
   localparam logic [PIPE_CTRL_W-1:0] PIPE_NOP_CTRL = '0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Generic saturating up-counter with increment enable and synchronous clear.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered IN_READY.
//
// state    | meaning
// ST_EMPTY | no entry held, outputs show the bubble
// ST_ONE   | main register holds the entry on OUT_*
// ST_TWO   | main and skid both hold entries, IN_READY low (skid build only)
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int                 CTRL_W      = PIPE_CTRL_W,
   parameter int                 DATA_W      = PIPE_DATA_W,
   parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(PIPE_NOP_CTRL),
   parameter int                 CNT_W       = PIPE_CNT_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Flush,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [CTRL_W-1:0] IN_CTRL,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [CTRL_W-1:0] OUT_CTRL,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic [1:0]        OCCUPANCY,
   output logic [CNT_W-1:0]  STALL_CNT
);

   pipe_state_t       r_state;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic              w_out_valid;
   logic              w_in_fire;
   logic              w_out_fire;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_in_fire   = IN_VALID & IN_READY;
   assign w_out_fire  = w_out_valid & OUT_READY;

`ifdef PIPE_STAGE_SKID_EN
   logic              r_in_ready;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;

   // Main register carries BUBBLE_CTRL itself while empty, so OUT_CTRL is a plain flop.
   always_ff @(posedge Clk) begin
      if (Reset || Flush) begin
         r_state     <= ST_EMPTY;
         r_main_ctrl <= BUBBLE_CTRL;
         r_main_data <= '0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  r_main_ctrl <= IN_CTRL;
                  r_main_data <= IN_DATA;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  r_main_ctrl <= IN_CTRL;
                  r_main_data <= IN_DATA;
               end else if (w_in_fire) begin
                  r_skid_ctrl <= IN_CTRL;
                  r_skid_data <= IN_DATA;
                  r_state     <= ST_TWO;
                  r_in_ready  <= 1'b0;
               end else if (w_out_fire) begin
                  r_main_ctrl <= BUBBLE_CTRL;
                  r_state     <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_out_fire) begin
                  r_main_ctrl <= r_skid_ctrl;
                  r_main_data <= r_skid_data;
                  r_state     <= ST_ONE;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_main_ctrl <= BUBBLE_CTRL;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign IN_READY  = r_in_ready;
   assign OCCUPANCY = (r_state == ST_TWO) ? 2'd2 :
                      (r_state == ST_ONE) ? 2'd1 : 2'd0;
`else
   always_ff @(posedge Clk) begin
      if (Reset || Flush) begin
         r_state     <= ST_EMPTY;
         r_main_ctrl <= BUBBLE_CTRL;
         r_main_data <= '0;
      end else if (w_in_fire) begin
         r_main_ctrl <= IN_CTRL;
         r_main_data <= IN_DATA;
         r_state     <= ST_ONE;
      end else if (w_out_fire) begin
         r_main_ctrl <= BUBBLE_CTRL;
         r_state     <= ST_EMPTY;
      end
   end

   assign IN_READY  = !w_out_valid || OUT_READY;
   assign OCCUPANCY = {1'b0, w_out_valid};
`endif

   assign OUT_VALID = w_out_valid;
   assign OUT_CTRL  = r_main_ctrl;
   assign OUT_DATA  = r_main_data;

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .i_clk (Clk),
      .i_clr (Reset),
      .i_inc (w_out_valid & ~OUT_READY),
      .o_cnt (STALL_CNT)
   );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: driver pushes accepted entries, negedge monitor pops and checks.
module tb_pipe_stage_elastic;

   localparam int              CW  = 8;
   localparam int              DW  = 16;
   localparam int              NW  = 4;
   localparam logic [CW-1:0]   BUB = 8'hA5;
   localparam int              SAT = 15;
`ifdef PIPE_STAGE_SKID_EN
   localparam int              MAXOCC = 2;
`else
   localparam int              MAXOCC = 1;
`endif

   logic          clk;
   logic          Reset, Flush, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
   logic [CW-1:0] IN_CTRL, OUT_CTRL;
   logic [DW-1:0] IN_DATA, OUT_DATA;
   logic [1:0]    OCCUPANCY;
   logic [NW-1:0] STALL_CNT;

   pipe_stage_elastic #(
      .CTRL_W      (CW),
      .DATA_W      (DW),
      .BUBBLE_CTRL (BUB),
      .CNT_W       (NW)
   ) dut (
      .Clk       (clk),
      .Reset     (Reset),
      .Flush     (Flush),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_CTRL   (IN_CTRL),
      .IN_DATA   (IN_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_CTRL  (OUT_CTRL),
      .OUT_DATA  (OUT_DATA),
      .OCCUPANCY (OCCUPANCY),
      .STALL_CNT (STALL_CNT)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: FIFO of accepted {ctrl,data}, last delivered data, saturating stall count.
   logic [CW+DW-1:0] q[$];
   logic [DW-1:0]    last_data = '0;
   int               exp_cnt = 0;
   int               n_cmp = 0;
   int               n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (Reset) begin
         exp_cnt = 0;
      end else begin
         chk("out_valid", 64'(OUT_VALID), 64'(q.size() != 0));
         chk("occupancy", 64'(OCCUPANCY), 64'(q.size()));
         chk("stall_cnt", 64'(STALL_CNT), 64'(exp_cnt));
`ifdef PIPE_STAGE_SKID_EN
         chk("in_ready", 64'(IN_READY), 64'(q.size() < 2));
`else
         chk("in_ready", 64'(IN_READY), 64'((q.size() == 0) || OUT_READY));
`endif
         if (q.size() != 0) begin
            chk("out_ctrl", 64'(OUT_CTRL), 64'(q[0][CW+DW-1:DW]));
            chk("out_data", 64'(OUT_DATA), 64'(q[0][DW-1:0]));
            if (OUT_READY) begin
               last_data = q[0][DW-1:0];
               void'(q.pop_front());
            end else if (exp_cnt < SAT) begin
               exp_cnt++;
            end
         end else begin
            chk("bubble_ctrl", 64'(OUT_CTRL), 64'(BUB));
            chk("idle_data", 64'(OUT_DATA), 64'(last_data));
         end
      end
   end

   task automatic step(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit rdy, input bit fl, input bit rst, output bit acc);
      @(posedge clk);
      #1;
      Reset     = rst;
      Flush     = fl;
      IN_VALID  = v;
      IN_CTRL   = c;
      IN_DATA   = d;
      OUT_READY = rdy;
      @(negedge clk);
      acc = v && IN_READY && !fl && !rst;
      #1;
      if (rst || fl) begin
         q.delete();
         last_data = '0;
      end else if (acc) begin
         q.push_back({c, d});
      end
   endtask

   task automatic do_reset();
      bit a;
      step(1'b1, 8'h11, 16'h1111, 1'b0, 1'b1, 1'b1, a);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, a);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            acc;
      logic [DW-1:0] pend[$];
      int            c;

      Reset = 1'b1; Flush = 1'b0; IN_VALID = 1'b0;
      IN_CTRL = '0; IN_DATA = '0; OUT_READY = 1'b0;

      // Reset values and a back-to-back stream 1..8.
      do_reset();
      chk("rst_in_ready", 64'(IN_READY), 64'(1));
      chk("rst_out_data", 64'(OUT_DATA), 64'(0));
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, CW'($urandom), DW'(i), 1'b1, 1'b0, 1'b0, acc);
         chk("t1_accept", 64'(acc), 64'(1));
      end
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
      chk("t1_stall", 64'(STALL_CNT), 64'(0));
      chk("t1_last", 64'(OUT_DATA), 64'(8));

      // Back-pressure three cycles while offering A, B, C.
      do_reset();
      pend = '{16'h000A, 16'h000B, 16'h000C};
      c = 0;
      while ((c < 30) && ((pend.size() != 0) || (q.size() != 0))) begin
         step(pend.size() != 0, 8'h40 + CW'(c), (pend.size() != 0) ? pend[0] : '0,
              c >= 4, 1'b0, 1'b0, acc);
         if (acc) void'(pend.pop_front());
         if (c == 2) begin
            chk("t2_occ_peak", 64'(OCCUPANCY), 64'(MAXOCC));
            chk("t2_in_ready", 64'(IN_READY), 64'(0));
         end
         c++;
      end
      chk("t2_drained", 64'(pend.size() + q.size()), 64'(0));
      chk("t2_stall", 64'(STALL_CNT), 64'(3));

      // Flush with stage full and a simultaneous 0xD offered.
      do_reset();
      step(1'b1, 8'h21, 16'h0A0A, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 8'h22, 16'h0B0B, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 8'h23, 16'h000D, 1'b0, 1'b1, 1'b0, acc);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
      chk("t3_valid", 64'(OUT_VALID), 64'(0));
      chk("t3_ctrl", 64'(OUT_CTRL), 64'(BUB));
      chk("t3_data", 64'(OUT_DATA), 64'(0));
      chk("t3_occ", 64'(OCCUPANCY), 64'(0));
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
      chk("t3_no_d", 64'(OUT_VALID), 64'(0));

      // Reset while holding a back-pressured entry.
      step(1'b1, 8'h31, 16'h5555, 1'b0, 1'b0, 1'b0, acc);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      chk("t4_valid", 64'(OUT_VALID), 64'(0));
      chk("t4_ctrl", 64'(OUT_CTRL), 64'(BUB));
      chk("t4_data", 64'(OUT_DATA), 64'(0));
      chk("t4_occ", 64'(OCCUPANCY), 64'(0));
      chk("t4_stall", 64'(STALL_CNT), 64'(0));
      chk("t4_in_ready", 64'(IN_READY), 64'(1));

      // Stall counter saturation survives a Flush.
      step(1'b1, 8'h41, 16'h7777, 1'b0, 1'b0, 1'b0, acc);
      for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      chk("t5_sat", 64'(STALL_CNT), 64'(SAT));
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
      chk("t5_sat_flush", 64'(STALL_CNT), 64'(SAT));
      chk("t5_empty", 64'(OUT_VALID), 64'(0));

      // Random traffic with occasional flushes.
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 3) != 0, CW'($urandom), DW'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, 1'b0, acc);
      end
      c = 0;
      while ((c < 10) && (q.size() != 0)) begin
         step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
         c++;
      end
      chk("rand_drained", 64'(q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
